// File: rtl/count_display_driver_pkg.sv
// Shared types and constants for the two-digit count display driver.
package count_disp_pkg;

  localparam int REFRESH_W_DEF   = 17;
  localparam int DEAD_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_ON0  = 2'd0,
    ST_GAP0 = 2'd1,
    ST_ON1  = 2'd2,
    ST_GAP1 = 2'd3
  } disp_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/count_display_driver_if.sv
// Count input and display pin bundle for count_display_driver.
interface count_display_driver_if;
  logic [3:0] count_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       upd;

  modport master (output count_in, input seg, an, dp, upd);
  modport slave  (input count_in, output seg, an, dp, upd);
endinterface

// File: rtl/count_display_driver_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (val_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Synchronises a 4-bit count and shows it as two multiplexed decimal digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module count_display_driver
  import count_disp_pkg::*;
#(
  parameter int REFRESH_W   = REFRESH_W_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  count_display_driver_if.slave        disp_io
);

  localparam logic [REFRESH_W-1:0] ON_TC   = '1;
  localparam logic [REFRESH_W-1:0] DEAD_TC = REFRESH_W'(DEAD_CYCLES - 1);

  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           cur_q, cur_d;
  logic [3:0]           shadow_q, shadow_d;
  logic                 upd_q, upd_d;
  disp_state_e          state_q, state_d;
  logic [REFRESH_W-1:0] rc_q, rc_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;
  logic                 dp_q;

  logic                 tens;
  logic [3:0]           ones;
  logic [3:0]           dec_in;
  logic [6:0]           dec_out;

  // Accept only when both sync stages agree, so a mid-transition sample is never taken
  always_comb begin
    cur_d = cur_q;
    upd_d = 1'b0;
    if ((sync1_q == sync2_q) && (sync2_q != cur_q)) begin
      cur_d = sync2_q;
      upd_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q + 1'b1;
    shadow_d = shadow_q;
    case (state_q)
      ST_ON0:  if (rc_q == ON_TC)   state_d = ST_GAP0;
      ST_GAP0: if (rc_q == DEAD_TC) state_d = ST_ON1;
      ST_ON1:  if (rc_q == ON_TC)   state_d = ST_GAP1;
      ST_GAP1: begin
        if (rc_q == DEAD_TC) begin
          state_d  = ST_ON0;
          shadow_d = cur_q;
        end
      end
      default: state_d = ST_GAP1;
    endcase
    if (state_d != state_q) rc_d = '0;
  end

  // Outputs are registered, so they are derived from next-state values
  assign tens   = (shadow_d >= 4'd10);
  assign ones   = tens ? (shadow_d - 4'd10) : shadow_d;
  assign dec_in = (state_d == ST_ON1) ? {3'b000, tens} : ones;

  seg7_decode u_dec (
    .val_i (dec_in),
    .seg_o (dec_out)
  );

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = 2'b11;
    case (state_d)
      ST_ON0: begin
        an_d  = 2'b10;
        seg_d = dec_out;
      end
      ST_ON1: begin
        an_d  = 2'b01;
        seg_d = dec_out;
`ifdef LEADING_ZERO_BLANK_EN
        if (!tens) seg_d = SEG_OFF;
`endif
      end
      default: begin
        an_d  = 2'b11;
        seg_d = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cur_q    <= '0;
      shadow_q <= '0;
      upd_q    <= 1'b0;
      state_q  <= ST_GAP1;
      rc_q     <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= 2'b11;
      dp_q     <= 1'b1;
    end else begin
      sync1_q  <= disp_io.count_in;
      sync2_q  <= sync1_q;
      cur_q    <= cur_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
      state_q  <= state_d;
      rc_q     <= rc_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= 1'b1;
    end
  end

  assign disp_io.seg = seg_q;
  assign disp_io.an  = an_q;
  assign disp_io.dp  = dp_q;
  assign disp_io.upd = upd_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver with a frame-position reference model.
module tb_count_display_driver;

  localparam int RW     = 4;
  localparam int DC     = 2;
  localparam int ON_LEN = 16;
  localparam int FRAME  = 2 * (ON_LEN + DC);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TZ = 7'h7F;
`else
  localparam logic [6:0] TZ = 7'b1000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt = 4'd0;

  count_display_driver_if disp_if ();
  assign disp_if.count_in = cnt;

  count_display_driver #(.REFRESH_W(RW), .DEAD_CYCLES(DC)) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_io (disp_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edges since reset release, last two sampled counts, accepted and shown values
  int         t_m      = 0;
  logic [3:0] s1_m     = 4'd0;
  logic [3:0] s2_m     = 4'd0;
  logic [3:0] cur_m    = 4'd0;
  logic [3:0] shadow_m = 4'd0;
  logic       upd_m    = 1'b0;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int phase();
    if (t_m < DC) return -1;
    return (t_m - DC) % FRAME;
  endfunction

  function automatic logic [1:0] exp_an();
    int ph = phase();
    if (ph < 0) return 2'b11;
    if (ph < ON_LEN) return 2'b10;
    if (ph < ON_LEN + DC) return 2'b11;
    if (ph < 2 * ON_LEN + DC) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [6:0] exp_seg();
    int ph = phase();
    int v  = int'(shadow_m);
    if (ph < 0) return 7'h7F;
    if (ph < ON_LEN) return seg_of(v % 10);
    if (ph < ON_LEN + DC) return 7'h7F;
    if (ph < 2 * ON_LEN + DC) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 10) return 7'h7F;
`endif
      return seg_of(v / 10);
    end
    return 7'h7F;
  endfunction

  task automatic model_edge();
    logic [3:0] cur_old;
    if (rst) begin
      t_m = 0; s1_m = 0; s2_m = 0; cur_m = 0; shadow_m = 0; upd_m = 1'b0;
    end else begin
      cur_old = cur_m;
      t_m++;
      upd_m = (s1_m == s2_m) && (s2_m != cur_m);
      if (upd_m) cur_m = s2_m;
      s2_m = s1_m;
      s1_m = cnt;
      if (t_m >= DC && ((t_m - DC) % FRAME) == 0) shadow_m = cur_old;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (time %0t, model edge %0d)", name, act, exp, $time, t_m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an",  32'(disp_if.an),  32'(exp_an()));
    chk("seg", 32'(disp_if.seg), 32'(exp_seg()));
    chk("dp",  32'(disp_if.dp),  32'd1);
    chk("upd", 32'(disp_if.upd), 32'(upd_m));
  endtask

  task automatic wait_phase(int ph);
    int k = 0;
    do begin
      tick();
      k++;
    end while (phase() != ph && k < 200);
    chk("wait_phase", 32'(phase()), 32'(ph));
  endtask

  task automatic settle(logic [3:0] v);
    cnt = v;
    repeat (4) tick();
    wait_phase(0);
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic [6:0] ones;
    logic [6:0] tens;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int on_cnt;
    int upd_pat;
    int upd_n;
    int hold;

    vecs[0] = '{4'd0,  7'b1000000, TZ};
    vecs[1] = '{4'd5,  7'b0010010, TZ};
    vecs[2] = '{4'd13, 7'b0110000, 7'b1111001};
    vecs[3] = '{4'd9,  7'b0010000, TZ};
    vecs[4] = '{4'd15, 7'b0010010, 7'b1111001};
    vecs[5] = '{4'd10, 7'b1000000, 7'b1111001};

    // Reset release: dark for DEAD_CYCLES, then "00" for 2^REFRESH_W cycles
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_an",  32'(disp_if.an),  32'h3);
    chk("rst_seg", 32'(disp_if.seg), 32'h7F);
    rst = 1'b0;
    tick();
    chk("rel_an_dark", 32'(disp_if.an), 32'h3);
    tick();
    chk("rel_an_on0",  32'(disp_if.an),  32'h2);
    chk("rel_seg_0",   32'(disp_if.seg), 32'h40);
    on_cnt = 1;
    repeat (20) begin
      tick();
      if (disp_if.an == 2'b10) on_cnt++;
    end
    chk("on0_len", 32'(on_cnt), 32'd16);

    // Acceptance 0 -> 5: single upd pulse on the third edge
    cnt = 4'd5;
    upd_pat = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      upd_pat |= int'(disp_if.upd) << i;
    end
    chk("acc_upd_pattern", 32'(upd_pat), 32'h4);
    wait_phase(0);
    wait_phase(5);
    chk("acc_ones5", 32'(disp_if.seg), 32'(7'b0010010));
    wait_phase(25);
    chk("acc_tens0", 32'(disp_if.seg), 32'(TZ));

    for (int i = 0; i < 6; i++) begin
      settle(vecs[i].cnt);
      wait_phase(5);
      chk("tbl_an_ones", 32'(disp_if.an),  32'h2);
      chk("tbl_ones",    32'(disp_if.seg), 32'(vecs[i].ones));
      wait_phase(25);
      chk("tbl_an_tens", 32'(disp_if.an),  32'h1);
      chk("tbl_tens",    32'(disp_if.seg), 32'(vecs[i].tens));
    end

    // No tearing: change 7 -> 12 mid ON1
    settle(4'd7);
    wait_phase(20);
    cnt = 4'd12;
    wait_phase(25);
    chk("tear_old_tens", 32'(disp_if.seg), 32'(TZ));
    wait_phase(5);
    chk("tear_new_ones", 32'(disp_if.seg), 32'(7'b0100100));
    wait_phase(25);
    chk("tear_new_tens", 32'(disp_if.seg), 32'(7'b1111001));

    // One-cycle glitch on bit 0 is never accepted
    settle(4'd3);
    cnt = 4'd2;
    upd_n = 0;
    tick();
    if (disp_if.upd) upd_n++;
    cnt = 4'd3;
    repeat (6) begin
      tick();
      if (disp_if.upd) upd_n++;
    end
    chk("glitch_no_upd", 32'(upd_n), 32'd0);

    // Wrap 15 -> 0
    settle(4'd15);
    cnt = 4'd0;
    upd_n = 0;
    repeat (8) begin
      tick();
      if (disp_if.upd) upd_n++;
    end
    chk("wrap_one_upd", 32'(upd_n), 32'd1);
    wait_phase(0);
    wait_phase(5);
    chk("wrap_ones0", 32'(disp_if.seg), 32'h40);
    wait_phase(25);
    chk("wrap_tens0", 32'(disp_if.seg), 32'(TZ));

    // Reset during ON1
    settle(4'd9);
    wait_phase(22);
    rst = 1'b1;
    tick();
    chk("mrst_an",     32'(disp_if.an),   32'h3);
    chk("mrst_seg",    32'(disp_if.seg),  32'h7F);
    chk("mrst_upd",    32'(disp_if.upd),  32'd0);
    chk("mrst_shadow", 32'(dut.shadow_q), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("mrst_on0_an",  32'(disp_if.an),  32'h2);
    chk("mrst_on0_seg", 32'(disp_if.seg), 32'h40);

    // Random count changes, checked every cycle by the model
    hold = 10;
    repeat (2500) begin
      hold--;
      if (hold <= 0) begin
        cnt  = 4'($urandom_range(0, 15));
        hold = int'($urandom_range(8, 60));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
